prog_loader: RTL and testbench
==============================

# prog_loader

Streaming program loader: the write side of the SPA1 instruction memory. Accepts a byte stream (length, instruction bytes, checksum) over a valid/ready handshake, writes the instructions into the instruction RAM from address 0 upward, and holds the CPU stopped until a complete, verified program is present. Sits between the host/serial front end and the instruction memory, alongside the CPU.

## Interface
- ADDR_W, 8, instruction memory address width (matches the PC width)
- DATA_W, 8, instruction width; also the stream byte width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  stream byte valid
- in_data  in  DATA_W  stream byte
- in_ready  out  1  loader can accept a byte; high only in LEN, DATA and CSUM
- mem_we  out  1  instruction RAM write strobe, one cycle per data byte
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- cpu_hold  out  1  1 = keep the CPU in reset/halt; 0 only in DONE
- busy  out  1  high in LEN, DATA, CSUM
- done  out  1  high in DONE
- error  out  1  high in ERROR

## Operation
- Handshake: a byte transfers on a rising edge with in_valid & in_ready. in_data is held by the source while in_valid is high and not accepted.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE: waits for start → LEN.
- LEN: the accepted byte is N. N = 0 means 2^ADDR_W bytes. Clear the byte counter (ADDR_W+1 bits) and checksum accumulator → DATA.
- DATA: each accepted byte is written to address = counter, then the counter increments. After the N-th byte → CSUM, or → DONE when the checksum is compiled out.
- CSUM: the accepted byte C is checked. If (sum of data bytes + C) mod 2^DATA_W == 0 → DONE, else → ERROR.
- DONE: cpu_hold = 0 and done = 1. start → LEN, with cpu_hold reasserting the next cycle.
- ERROR: error = 1 and cpu_hold = 1. start → LEN. The error flag clears on leaving ERROR.
- start is ignored in LEN, DATA and CSUM. Stream bytes are not accepted in IDLE, DONE or ERROR.
- Address arithmetic: mem_addr = counter[ADDR_W-1:0]. The counter never exceeds N, so there is no address wrap within a load. With N = 256, the final write is to address 255.
- Partially written memory is never cleared: after a failed or aborted load, the RAM holds whatever was written.

## Timing
- Reset (asserted low, asynchronous): state = IDLE, counter = 0, checksum = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, in_ready = 0, busy = 0, done = 0, error = 0, cpu_hold = 1.
- Reset mid-load: same values immediately. No further writes occur.
- start sampled at edge t → state LEN from t+1, so in_ready is high in cycle t+1.
- Write latency: mem_we, mem_addr and mem_wdata are registered. For a data byte accepted at edge t, they are valid in cycle t+1, and mem_we is high for exactly that one cycle.
- Back-to-back bytes with in_valid held high: one accepted per cycle, no bubbles.
- Last data byte accepted at edge t → state CSUM at t+1. C accepted at edge u → done/error and cpu_hold update at u+1.
- Last data byte write (cycle t+1) completes before cpu_hold can fall (earliest u+1 ≥ t+2).

## Configuration
- PROG_LOADER_CHECKSUM_EN defined: CSUM state, the checksum accumulator and the ERROR state are all built. Behaviour is as described above.
- PROG_LOADER_CHECKSUM_EN undefined: no checksum byte is expected. DATA goes directly to DONE after the N-th byte. error is tied to 0, and ERROR is unreachable.

## Test plan
- Reset: hold reset low → cpu_hold = 1, in_ready = 0, mem_we = 0, done = error = 0. Release reset with no start → remains IDLE indefinitely.
- Good load: start; then stream 03, 41, 82, C3, 3A (sum 0x186 + 0x3A = 0x1C0, so 0xC0 ≠ 0 → use C = 0x7A). Required: writes 0:41, 1:82, 2:C3 on consecutive cycles; done = 1 and cpu_hold = 0 one cycle after C is accepted.
- Bad checksum: same stream with C = 0x00 → error = 1, cpu_hold stays 1. Then start followed by the good stream → done = 1.
- N = 0: stream 256 bytes of value i, then C = 0x80 (sum is 0x7F80) → exactly 256 writes to addresses 0..255, then done.
- Backpressure and ignored inputs: toggle in_valid randomly → only accepted bytes are written, in order. start pulsed during DATA is ignored. in_valid during DONE → in_ready = 0 and no write.
- Mid-load reset: assert reset after 2 of 5 data bytes → outputs return to reset values immediately with no further mem_we. A fresh load then succeeds. With the macro undefined: 02, AA, BB → done right after BB, error never asserts.

Source files
------------

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streaming program loader for the instruction RAM; checksum
// stage built only when PROG_LOADER_CHECKSUM_EN is defined.
module prog_loader #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] LEN_FULL = CNT_W'(1) << ADDR_W;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  len_q, len_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic              accept;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [DATA_W-1:0] csum_total;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_q       <= sum_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      in_ready    = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
      accept      = in_valid & in_ready;
      cnt_inc     = cnt_q + CNT_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_d       = sum_q;
      csum_total  = sum_q + in_data;
`endif
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) state_d = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               // A zero length byte stands for a full memory image.
               len_d   = (in_data == '0) ? LEN_FULL : CNT_W'(in_data);
               cnt_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d   = '0;
`endif
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               mem_we_d    = 1'b1;
               mem_addr_d  = cnt_q[ADDR_W-1:0];
               mem_wdata_d = in_data;
               cnt_d       = cnt_inc;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_d       = csum_total;
               if (cnt_inc == len_q) state_d = S_CSUM;
`else
               if (cnt_inc == len_q) state_d = S_DONE;
`endif
            end
         end
`ifdef PROG_LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (accept) state_d = (csum_total == '0) ? S_DONE : S_ERROR;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
   assign done      = (state_q == S_DONE);
   assign cpu_hold  = (state_q != S_DONE);
`ifdef PROG_LOADER_CHECKSUM_EN
   assign error     = (state_q == S_ERROR);
`else
   assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - self-checking bench for prog_loader; expectations follow
// PROG_LOADER_CHECKSUM_EN so either build can be exercised.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       mem_we;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       error;

   int checks;
   int failures;

   logic [7:0] wr_a[$];
   logic [7:0] wr_d[$];

   prog_loader #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_hold  (cpu_hold),
      .busy      (busy),
      .done      (done),
      .error     (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_a.push_back(mem_addr);
         wr_d.push_back(mem_wdata);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic       st;
      logic       v;
      logic [7:0] d;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wd;
      logic       rdy;
      logic       dn;
      logic       er;
      logic       hold;
   } vec_t;

   vec_t vecs[21];

   function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                               input logic we, input logic [7:0] addr, input logic [7:0] wd,
                               input logic rdy, input logic dn, input logic er, input logic hold);
      vec_t r;
      r.st = st; r.v = v; r.d = d; r.we = we; r.addr = addr; r.wd = wd;
      r.rdy = rdy; r.dn = dn; r.er = er; r.hold = hold;
      return r;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input int max_bub);
      int nb;
      int w;
      nb = (max_bub > 0) ? int'($urandom_range(0, max_bub)) : 0;
      for (int k = 0; k < nb; k++) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         start    = 1'($urandom_range(0, 1));
         step();
      end
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = b;
      w = 0;
      while (!in_ready && w < 8) begin
         step();
         w++;
      end
      if (w == 8) begin
         checks++;
         failures++;
         $display("FAIL send_ready got=0 exp=1 byte=%h", b);
      end
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_queue(input string name, input logic [7:0] a[$], input logic [7:0] d[$]);
      check({name, "_count"}, wr_a.size(), a.size());
      for (int i = 0; i < a.size() && i < wr_a.size(); i++) begin
         check($sformatf("%s_addr%0d", name, i), wr_a[i], a[i]);
         check($sformatf("%s_data%0d", name, i), wr_d[i], d[i]);
      end
   endtask

   initial begin
      logic [7:0] ea[$];
      logic [7:0] ed[$];
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      vecs[0]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0, 0, 1);
      vecs[1]  = mk(0, 1, 8'h03, 0, 8'h00, 8'h00, 1, 0, 0, 1);
      vecs[2]  = mk(0, 1, 8'h41, 1, 8'h00, 8'h41, 1, 0, 0, 1);
      vecs[3]  = mk(1, 0, 8'h00, 0, 8'h00, 8'h41, 1, 0, 0, 1);
      vecs[4]  = mk(0, 1, 8'h82, 1, 8'h01, 8'h82, 1, 0, 0, 1);
      vecs[5]  = mk(0, 1, 8'hC3, 1, 8'h02, 8'hC3, CK, !CK, 0, CK);
      vecs[6]  = mk(0, 1, 8'h7A, 0, 8'h02, 8'hC3, 0, 1, 0, 0);
      vecs[7]  = mk(0, 1, 8'h55, 0, 8'h02, 8'hC3, 0, 1, 0, 0);
      vecs[8]  = mk(1, 0, 8'h00, 0, 8'h02, 8'hC3, 1, 0, 0, 1);
      vecs[9]  = mk(0, 1, 8'h03, 0, 8'h02, 8'hC3, 1, 0, 0, 1);
      vecs[10] = mk(0, 1, 8'h41, 1, 8'h00, 8'h41, 1, 0, 0, 1);
      vecs[11] = mk(0, 1, 8'h82, 1, 8'h01, 8'h82, 1, 0, 0, 1);
      vecs[12] = mk(0, 1, 8'hC3, 1, 8'h02, 8'hC3, CK, !CK, 0, CK);
      vecs[13] = mk(0, 1, 8'h00, 0, 8'h02, 8'hC3, 0, !CK, CK, CK);
      vecs[14] = mk(0, 0, 8'h00, 0, 8'h02, 8'hC3, 0, !CK, CK, CK);
      vecs[15] = mk(1, 0, 8'h00, 0, 8'h02, 8'hC3, 1, 0, 0, 1);
      vecs[16] = mk(0, 1, 8'h02, 0, 8'h02, 8'hC3, 1, 0, 0, 1);
      vecs[17] = mk(0, 0, 8'h00, 0, 8'h02, 8'hC3, 1, 0, 0, 1);
      vecs[18] = mk(0, 1, 8'hAA, 1, 8'h00, 8'hAA, 1, 0, 0, 1);
      vecs[19] = mk(0, 1, 8'hBB, 1, 8'h01, 8'hBB, CK, !CK, 0, CK);
      vecs[20] = mk(0, 1, 8'h9B, 0, 8'h01, 8'hBB, 0, 1, 0, 0);

      // Reset held low: outputs at reset values before any clock edge.
      #2;
      check("rst_hold", cpu_hold, 1);
      check("rst_ready", in_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_busy", busy, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      step();
      step();
      reset = 1'b1;
      for (int i = 0; i < 20; i++) step();
      check("idle_ready", in_ready, 0);
      check("idle_hold", cpu_hold, 1);
      check("idle_done", done, 0);
      check("idle_busy", busy, 0);
      check("idle_writes", wr_a.size(), 0);

      for (int i = 0; i < 21; i++) begin
         start    = vecs[i].st;
         in_valid = vecs[i].v;
         in_data  = vecs[i].d;
         step();
         check($sformatf("v%0d_we", i), mem_we, vecs[i].we);
         check($sformatf("v%0d_addr", i), mem_addr, vecs[i].addr);
         check($sformatf("v%0d_wdata", i), mem_wdata, vecs[i].wd);
         check($sformatf("v%0d_ready", i), in_ready, vecs[i].rdy);
         check($sformatf("v%0d_busy", i), busy, vecs[i].rdy);
         check($sformatf("v%0d_done", i), done, vecs[i].dn);
         check($sformatf("v%0d_error", i), error, vecs[i].er);
         check($sformatf("v%0d_hold", i), cpu_hold, vecs[i].hold);
      end
      start    = 1'b0;
      in_valid = 1'b0;
      step();

      // Mid-load reset after two of five data bytes.
      wr_a.delete();
      wr_d.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      send(8'h05, 0);
      send(8'h11, 0);
      send(8'h22, 0);
      step();
      check("mid_addr_pre", mem_addr, 8'h01);
      #1;
      reset = 1'b0;
      #1;
      check("mid_we", mem_we, 0);
      check("mid_ready", in_ready, 0);
      check("mid_hold", cpu_hold, 1);
      check("mid_busy", busy, 0);
      check("mid_addr", mem_addr, 0);
      check("mid_wdata", mem_wdata, 0);
      in_valid = 1'b1;
      in_data  = 8'h33;
      for (int i = 0; i < 3; i++) step();
      reset    = 1'b1;
      in_valid = 1'b0;
      step();
      step();
      check("mid_idle_ready", in_ready, 0);
      check("mid_idle_done", done, 0);
      ea = '{8'h00, 8'h01};
      ed = '{8'h11, 8'h22};
      check_queue("mid", ea, ed);

      wr_a.delete();
      wr_d.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      send(8'h03, 0);
      send(8'h10, 0);
      send(8'h20, 0);
      send(8'h30, 0);
      if (CK) send(8'hA0, 0);
      step();
      check("fresh_done", done, 1);
      check("fresh_hold", cpu_hold, 0);
      check("fresh_error", error, 0);
      ea = '{8'h00, 8'h01, 8'h02};
      ed = '{8'h10, 8'h20, 8'h30};
      check_queue("fresh", ea, ed);

      // Full 256-byte image with random bubbles and ignored start pulses.
      wr_a.delete();
      wr_d.delete();
      ea.delete();
      ed.delete();
      start = 1'b1;
      step();
      start = 1'b0;
      send(8'h00, 0);
      for (int i = 0; i < 256; i++) begin
         send(8'(i), 2);
         ea.push_back(8'(i));
         ed.push_back(8'(i));
      end
      check("n0_done_early", done, !CK);
      if (CK) send(8'h80, 2);
      step();
      step();
      check("n0_done", done, 1);
      check("n0_hold", cpu_hold, 0);
      check("n0_error", error, 0);
      check("n0_last_addr", mem_addr, 8'hFF);
      check_queue("n0", ea, ed);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
